predecode_ir: RTL

//  Opcode predecode and instruction-register stage; sits beside timing_generator.
//  - Captures the fetched opcode from the data bus into the predecode register (PD).
//  - Drives tz_pre_n back into timing_generator.
//  - Loads the instruction register (IR) one cycle later.
//  - Substitutes BRK (0x00) when an interrupt was pending at fetch.

---
 rtl/predecode_ir_pkg.sv | 57 +++++
 rtl/predecode_ir_classifier.sv | 19 +
 rtl/predecode_ir.sv | 120 ++++++++++++
 3 files changed

// File: rtl/predecode_ir_pkg.sv
// Shared 6502 opcode definitions for the predecode/IR stage: opcode constants,
// opcode-field accessors and the opcode-class decode used by opcode_classifier.
package predecode_ir_pkg;

    localparam logic [7:0] OP_BRK     = 8'h00;

    // Low-nibble groups that contain two-cycle (implied/immediate) opcodes
    localparam logic [3:0] LO_IMPL_A  = 4'hA;
    localparam logic [3:0] LO_IMPL_8  = 4'h8;
    localparam logic [3:0] LO_IMM_9   = 4'h9;
    localparam logic [3:0] LO_IMM_0   = 4'h0;
    localparam logic [3:0] LO_IMM_2   = 4'h2;
    localparam logic [3:0] LO_JAM     = 4'h2;

    typedef struct packed {
        logic two_cyc;
        logic jam;
    } op_class_t;

    function automatic logic [3:0] low_nib(input logic [7:0] p);
        return p[3:0];
    endfunction

    function automatic logic p4(input logic [7:0] p);
        return p[4];
    endfunction

    function automatic logic p7(input logic [7:0] p);
        return p[7];
    endfunction

    // Two-cycle set; column 0 with p4=1 is the branch column and must stay excluded
    function automatic logic is_two_cyc(input logic [7:0] p);
        logic r;
        case (low_nib(p))
            LO_IMPL_A: r = 1'b1;
            LO_IMPL_8: r = p7(p) | p4(p);
            LO_IMM_9:  r = ~p4(p);
            LO_IMM_0,
            LO_IMM_2:  r = p7(p) & ~p4(p);
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_jam(input logic [7:0] p);
        return (low_nib(p) == LO_JAM) && (~p7(p) || p4(p));
    endfunction

    function automatic op_class_t classify(input logic [7:0] p);
        op_class_t c;
        c.two_cyc = is_two_cyc(p);
        c.jam     = is_jam(p);
        return c;
    endfunction

endpackage

// File: rtl/predecode_ir_classifier.sv
// Purely combinational opcode classifier: flags two-cycle and jam opcodes.
module opcode_classifier
    import predecode_ir_pkg::*;
(
    input  logic [7:0] op_i,
    output logic       two_cyc_o,
    output logic       jam_o
);

    op_class_t cls_s;

    // Decode the opcode class from the predecode byte
    always_comb begin
        cls_s     = classify(op_i);
        two_cyc_o = cls_s.two_cyc;
        jam_o     = cls_s.jam;
    end

endmodule

// File: rtl/predecode_ir.sv
// Opcode predecode register (PD) and instruction register (IR) beside timing_generator.
// Optional jam-opcode halt is enabled by defining KIL_DETECT_EN.
module predecode_ir
    import predecode_ir_pkg::*;
#(
    parameter logic [7:0] PD_RESET_VAL = 8'h00,
    parameter logic [7:0] IR_RESET_VAL = OP_BRK,
    parameter logic [7:0] FORCE_OPCODE = OP_BRK
) (
    input  logic       clk_0,
    input  logic       res_n,
    input  logic       rdy,
    input  logic       fetch,
    input  logic [7:0] db,
    input  logic       int_pending,
    output logic [7:0] pd,
    output logic [7:0] ir,
    output logic       tz_pre_n,
    output logic       ir_loaded,
    output logic       int_taken,
    output logic       kil
);

`ifdef KIL_DETECT_EN
    localparam logic KIL_EN = 1'b1;
`else
    localparam logic KIL_EN = 1'b0;
`endif

    logic [7:0] pd_q, pd_d;
    logic [7:0] ir_q, ir_d;
    logic       op_pend_q, op_pend_d;
    logic       int_q, int_d;
    logic       ir_loaded_q, ir_loaded_d;
    logic       int_taken_q, int_taken_d;
    logic       kil_q, kil_d;

    logic       two_cyc_s;
    logic       jam_s;
    logic       capture_s;
    logic       load_s;

    opcode_classifier u_classifier (
        .op_i      (pd_q),
        .two_cyc_o (two_cyc_s),
        .jam_o     (jam_s)
    );

    // Capture/load decisions and next-state for all stage registers
    always_comb begin
        pd_d        = pd_q;
        ir_d        = ir_q;
        op_pend_d   = op_pend_q;
        int_d       = int_q;
        kil_d       = kil_q;
        ir_loaded_d = 1'b0;
        int_taken_d = 1'b0;

        capture_s = fetch & rdy;
        load_s    = op_pend_q & rdy & ~kil_q;

        if (capture_s) begin
            pd_d  = db;
            int_d = int_pending;
        end else begin
            pd_d  = pd_q;
            int_d = int_q;
        end

        // Load uses the old PD, so a same-edge capture is a legal back-to-back fetch
        if (load_s) begin
            ir_d        = int_q ? FORCE_OPCODE : pd_q;
            ir_loaded_d = 1'b1;
            int_taken_d = int_q;
            kil_d       = kil_q | (KIL_EN & ~int_q & jam_s);
        end else begin
            ir_d        = ir_q;
        end

        if (capture_s) begin
            op_pend_d = 1'b1;
        end else if (load_s) begin
            op_pend_d = 1'b0;
        end else begin
            op_pend_d = op_pend_q;
        end
    end

    // Stage registers; async reset discards any pending load
    always_ff @(posedge clk_0 or negedge res_n) begin
        if (!res_n) begin
            pd_q        <= PD_RESET_VAL;
            ir_q        <= IR_RESET_VAL;
            op_pend_q   <= 1'b0;
            int_q       <= 1'b0;
            ir_loaded_q <= 1'b0;
            int_taken_q <= 1'b0;
            kil_q       <= 1'b0;
        end else begin
            pd_q        <= pd_d;
            ir_q        <= ir_d;
            op_pend_q   <= op_pend_d;
            int_q       <= int_d;
            ir_loaded_q <= ir_loaded_d;
            int_taken_q <= int_taken_d;
            kil_q       <= kil_d;
        end
    end

    // Outputs derive from registers only, so tz_pre_n cannot glitch
    always_comb begin
        pd        = pd_q;
        ir        = ir_q;
        ir_loaded = ir_loaded_q;
        int_taken = int_taken_q;
        kil       = kil_q;
        tz_pre_n  = ~(op_pend_q & ~int_q & two_cyc_s & ~kil_q);
    end

endmodule
